// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage, one outstanding imem request, one-entry output.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic                discard_q, discard_d;
    logic                inst_valid_q, inst_valid_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic [INST_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;

    logic out_fire;
    logic out_free;
    logic req_acc;
    logic resp_live;

    assign out_fire  = inst_valid_q && inst_ready;
    assign out_free  = !inst_valid_q || inst_ready;
    assign req_acc   = (state_q == S_REQ) && imem_req_ready;
    // A response is usable only in WAIT and only if not made stale by a redirect.
    assign resp_live = (state_q == S_WAIT) && imem_resp_valid
                       && !discard_q && !redirect_valid;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC & ALIGN_MASK;
            req_pc_q     <= '0;
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            hold_q       <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            hold_q       <= hold_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state logic; a redirect always leaves HOLD and ends a WAIT on response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid || discard_q || out_free) state_d = S_REQ;
                    else state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // PC, discard flag, hold buffer and output register updates
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        hold_d       = hold_q;
        hold_pc_d    = hold_pc_q;

        if (req_acc) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end

        if ((state_q == S_WAIT) && imem_resp_valid) discard_d = 1'b0;

        if (out_fire) inst_valid_d = 1'b0;

        if (resp_live && out_free) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_resp_data;
            inst_pc_d    = req_pc_q;
        end

        if (resp_live && !out_free) begin
            hold_d    = imem_resp_data;
            hold_pc_d = req_pc_q;
        end

        if ((state_q == S_HOLD) && inst_ready && !redirect_valid) begin
            inst_valid_d = 1'b1;
            inst_d       = hold_q;
            inst_pc_d    = hold_pc_q;
        end

        // Redirect wins: an issued-but-unanswered request must have its reply dropped.
        if (redirect_valid) begin
            pc_d         = redirect_pc & ALIGN_MASK;
            inst_valid_d = 1'b0;
            if (req_acc || ((state_q == S_WAIT) && !imem_resp_valid))
                discard_d = 1'b1;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_req_addr  = pc_q;
        inst_valid     = inst_valid_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Consumed-instruction and decoder-stall counters, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (out_fire) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (inst_valid_q && !inst_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the RV32 decoder. It owns the PC and issues word fetches to instruction memory over a valid/ready request channel. It holds each returned instruction in a one-entry output register and presents it with its PC to the decoder over a valid/ready handshake. It accepts redirects (branch/jump target) from later stages, discarding stale in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width
INST_W, 32, instruction width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  word-aligned fetch address
imem_resp_valid  input  1  response data valid, one per accepted request
imem_resp_data  input  INST_W  fetched instruction word
inst_valid  output  1  instruction available to decoder
inst_ready  input  1  decoder consumes instruction
inst  output  INST_W  instruction to decoder
inst_pc  output  ADDR_W  PC of inst
redirect_valid  input  1  redirect request, single-cycle pulse
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)

Behaviour:
- One clock (clk); rst is synchronous, active-high; sampled only on the rising edge of clk.
- Reset values: pc=RESET_PC, state=REQ, discard=0, inst_valid=0, inst=0, inst_pc=0. imem_req_valid is 1 in the first cycle after reset.
- At most one outstanding memory request.
- Memory responds no earlier than 1 cycle after request acceptance; latency is otherwise arbitrary.
- FSM states:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, latch req_pc=pc, pc<=pc+4 (modulo 2^ADDR_W, 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid with discard=0:
    - If the output register is free (!inst_valid, or inst_valid&&inst_ready this cycle): load inst<=imem_resp_data, inst_pc<=req_pc, inst_valid<=1, go to REQ.
    - Otherwise: capture into the output register is deferred. Store the word in a one-entry hold buffer and go to HOLD.
  - HOLD: on inst_ready, move the hold buffer into the output register (inst_valid stays 1), go to REQ.
- Output register: inst_valid clears on inst_valid&&inst_ready unless reloaded in the same cycle. inst/inst_pc are stable while inst_valid&&!inst_ready.
- Redirect (highest priority, any state):
  - pc<=redirect_pc&~3, inst_valid<=0, hold buffer invalidated.
  - In WAIT without response this cycle: discard<=1, stay in WAIT. Next response is dropped, then go to REQ.
  - In WAIT with response this cycle: response dropped, go to REQ.
  - In REQ with imem_req_ready the same cycle: request counts as issued. Set discard<=1 and go to WAIT.
  - In HOLD: go to REQ.
  - Redirect in the same cycle as inst_valid&&inst_ready: the handshake completes; redirect still applies.
- rst mid-operation: any in-flight response after reset deassertion is an environment error. Memory must also be reset.
- imem_resp_valid outside WAIT: ignored.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched (32) and perf_stall (32), both reset to 0.
  - perf_fetched increments on each inst_valid&&inst_ready.
  - perf_stall increments on each cycle with inst_valid&&!inst_ready.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, 1-cycle memory, inst_ready=1 -> addresses 0x0,0x4,0x8 issued in order; inst_pc sequence 0x0,0x4,0x8 with matching data (0x00B50533 at 0x0).
- inst_ready=0 for 5 cycles after first response -> inst/inst_pc held at 0x00B50533/0x0. No second request beyond one outstanding. After ready, next inst_pc=0x4.
- Redirect to 0x100 while waiting on response for 0x8 -> response for 0x8 dropped, inst_valid never shows pc 0x8, next request addr=0x100.
- redirect_pc=0x203 -> imem_req_addr=0x200.
- RESET_PC=32'hFFFF_FFFC -> requests 0xFFFFFFFC then 0x0.
- FETCH_PERF_CNT_EN defined, 3 instructions consumed with 4 stall cycles -> perf_fetched=3, perf_stall=4; rst clears both to 0.
